// File: rtl/led_pkg.sv
// Shared encodings and helpers for the LED pattern engine.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package led_pkg;

    // Pattern selection as presented on the mode input.
    typedef enum logic [1:0] {
        MODE_ROTATE = 2'b00,
        MODE_BOUNCE = 2'b01,
        MODE_FILL   = 2'b10,
        MODE_BLINK  = 2'b11
    } mode_t;

    // Travel direction of the single lit bit in bounce mode.
    typedef enum logic {
        BDIR_UP   = 1'b0,
        BDIR_DOWN = 1'b1
    } bdir_t;

    // Half of the fill/drain cycle currently in progress.
    typedef enum logic {
        PHASE_FILL  = 1'b0,
        PHASE_DRAIN = 1'b1
    } phase_t;

    // Widest LED vector any instance may use; callers truncate to N_LED.
    localparam int LED_MAX = 32;

    // Pattern loaded on a mode change; also the value whose recurrence
    // after a step marks the end of one pattern period.
    function automatic logic [LED_MAX-1:0] init_pattern(input mode_t m);
        logic [LED_MAX-1:0] p;
        p = '0;
        case (m)
            MODE_ROTATE: p = LED_MAX'(1);
            MODE_BOUNCE: p = LED_MAX'(1);
            MODE_FILL:   p = '0;
            MODE_BLINK:  p = '0;
            default:     p = '0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Step-rate divider: one-cycle tick every (TICK_BASE >> speed) running cycles.
// Latency: tick is combinational from the counter register; speed changes act at once.
// Backpressure: run_i=0 freezes the count; clr_i restarts it from zero.
module led_tick_gen
    import led_pkg::*;
#(
    parameter int TICK_BASE = 25_000_000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       run_i,
    input  logic       clr_i,
    input  logic [1:0] speed_i,
    output logic       tick_o
);

    localparam int CW = $clog2(TICK_BASE);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   limit;
    logic          at_limit;

    // Terminal count for the selected speed. The compare is ">=" so that a
    // switch to a shorter period fires straight away instead of counting
    // all the way round the counter.
    always_comb begin
        limit    = (32'(TICK_BASE) >> speed_i) - 32'd1;
        at_limit = (32'(cnt_q) >= limit);
        tick_o   = run_i && at_limit;
    end

    // Next count: clear wins, otherwise advance or wrap only while running.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (run_i) begin
            if (at_limit) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_pattern_engine.sv
// LED pattern generator: rotate, bounce, fill/drain and blink at four speeds.
// Latency: LED and wrap are registered; a step lands one cycle after its tick.
// Backpressure: none; run=0 pauses the pattern and step timer in place.
module led_pattern_engine
    import led_pkg::*;
#(
    parameter int N_LED     = 16,
    parameter int TICK_BASE = 25_000_000
) (
    input  logic             CLK100MHZ,
    input  logic             CPU_RESET,
    input  logic             run,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic [1:0]       speed,
    output logic [N_LED-1:0] LED,
    output logic             wrap
);

    mode_t            mode_q, mode_d;
    logic [N_LED-1:0] led_q, led_d;
    bdir_t            bdir_q, bdir_d;
    phase_t           phase_q, phase_d;
    logic             wrap_q, wrap_d;

    logic             tick;
    logic             mode_chg;
    logic [N_LED-1:0] step_led;
    bdir_t            step_bdir;
    phase_t           step_phase;
    logic [N_LED-1:0] reload_led;
    logic [N_LED-1:0] home_led;

    // A mode change restarts the step timer so the new pattern gets a full
    // first period.
    led_tick_gen #(
        .TICK_BASE (TICK_BASE)
    ) u_tick_gen (
        .clk_i   (CLK100MHZ),
        .rst_i   (CPU_RESET),
        .run_i   (run),
        .clr_i   (mode_chg),
        .speed_i (speed),
        .tick_o  (tick)
    );

    // Detect a mode request and look up the reload / period-start patterns.
    always_comb begin
        mode_chg   = (mode != mode_q);
        reload_led = N_LED'(init_pattern(mode_t'(mode)));
        home_led   = N_LED'(init_pattern(mode_q));
    end

    // Result of one step in the current mode, plus any direction/phase flip
    // caused by reaching an end of the bar.
    always_comb begin
        step_led   = led_q;
        step_bdir  = bdir_q;
        step_phase = phase_q;
        case (mode_q)
            MODE_ROTATE: begin
                if (dir) begin
                    step_led = {led_q[0], led_q[N_LED-1:1]};
                end else begin
                    step_led = {led_q[N_LED-2:0], led_q[N_LED-1]};
                end
            end
            MODE_BOUNCE: begin
                if (bdir_q == BDIR_UP) begin
                    step_led = led_q << 1;
                    if (step_led[N_LED-1]) begin
                        step_bdir = BDIR_DOWN;
                    end
                end else begin
                    step_led = led_q >> 1;
                    if (step_led[0]) begin
                        step_bdir = BDIR_UP;
                    end
                end
            end
            MODE_FILL: begin
                if (phase_q == PHASE_FILL) begin
                    step_led = {led_q[N_LED-2:0], 1'b1};
                    if (&step_led) begin
                        step_phase = PHASE_DRAIN;
                    end
                end else begin
                    step_led = {led_q[N_LED-2:0], 1'b0};
                    if (~|step_led) begin
                        step_phase = PHASE_FILL;
                    end
                end
            end
            MODE_BLINK: begin
                step_led = (~|led_q) ? {N_LED{1'b1}} : {N_LED{1'b0}};
            end
            default: begin
                step_led = led_q;
            end
        endcase
    end

    // Next state: a mode change reloads and suppresses the step; otherwise
    // a tick commits the step. wrap flags a step that lands back on the
    // period-start pattern, never a reload.
    always_comb begin
        mode_d  = mode_q;
        led_d   = led_q;
        bdir_d  = bdir_q;
        phase_d = phase_q;
        wrap_d  = 1'b0;
        if (mode_chg) begin
            mode_d  = mode_t'(mode);
            led_d   = reload_led;
            bdir_d  = BDIR_UP;
            phase_d = PHASE_FILL;
        end else if (tick) begin
            led_d   = step_led;
            bdir_d  = step_bdir;
            phase_d = step_phase;
            wrap_d  = (step_led == home_led);
        end
    end

    // State registers; reset comes up in rotate mode showing bit 0.
    always_ff @(posedge CLK100MHZ) begin
        if (CPU_RESET) begin
            mode_q  <= MODE_ROTATE;
            led_q   <= N_LED'(1);
            bdir_q  <= BDIR_UP;
            phase_q <= PHASE_FILL;
            wrap_q  <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            led_q   <= led_d;
            bdir_q  <= bdir_d;
            phase_q <= phase_d;
            wrap_q  <= wrap_d;
        end
    end

    assign LED  = led_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_led_pattern_engine.sv
// Self-checking bench for led_pattern_engine against a step-count reference model.
// Latency: outputs compared 1 time unit after every rising edge.
// Backpressure: n/a; directed scenarios followed by randomized stimulus.
module tb_led_pattern_engine;

    localparam int N  = 4;
    localparam int TB = 8;

    logic         clk = 1'b0;
    logic         s_rst;
    logic         s_run;
    logic [1:0]   s_mode;
    logic         s_dir;
    logic [1:0]   s_speed;
    logic [N-1:0] led;
    logic         wrap;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference state: pattern described by mode, steps taken since the
    // last reload (bounce/fill/blink) or lit position (rotate), timer count.
    int m_mq   = 0;
    int m_k    = 0;
    int m_pos  = 0;
    int m_cnt  = 0;
    bit m_wrap = 1'b0;

    always #5 clk = ~clk;

    led_pattern_engine #(
        .N_LED     (N),
        .TICK_BASE (TB)
    ) dut (
        .CLK100MHZ (clk),
        .CPU_RESET (s_rst),
        .run       (s_run),
        .mode      (s_mode),
        .dir       (s_dir),
        .speed     (s_speed),
        .LED       (led),
        .wrap      (wrap)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    // Expected LED derived from the step count with plain arithmetic.
    function automatic int model_led();
        int b, p, f, full;
        full = (1 << N) - 1;
        case (m_mq)
            0: return 1 << m_pos;
            1: begin
                b = m_k % (2*N - 2);
                p = (b < N) ? b : (2*N - 2 - b);
                return 1 << p;
            end
            2: begin
                f = m_k % (2*N);
                if (f <= N) return (1 << f) - 1;
                return (full << (f - N)) & full;
            end
            default: return (m_k % 2 == 1) ? full : 0;
        endcase
    endfunction

    function automatic bit model_at_start();
        case (m_mq)
            0:       return m_pos == 0;
            1:       return (m_k % (2*N - 2)) == 0;
            2:       return (m_k % (2*N)) == 0;
            default: return (m_k % 2) == 0;
        endcase
    endfunction

    // Advance the reference by one clock edge using the applied inputs.
    task automatic model_edge();
        int  period;
        bit  tk;
        period = TB >> s_speed;
        if (s_rst) begin
            m_mq = 0; m_k = 0; m_pos = 0; m_cnt = 0; m_wrap = 1'b0;
        end else if (int'(s_mode) != m_mq) begin
            m_mq = int'(s_mode); m_k = 0; m_pos = 0; m_cnt = 0; m_wrap = 1'b0;
        end else begin
            tk = s_run && (m_cnt >= period - 1);
            if (s_run) m_cnt = tk ? 0 : m_cnt + 1;
            m_wrap = 1'b0;
            if (tk) begin
                if (m_mq == 0) m_pos = s_dir ? (m_pos + N - 1) % N : (m_pos + 1) % N;
                else m_k++;
                m_wrap = model_at_start();
            end
        end
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            #1;
            check("led_model", 32'(led), 32'(model_led()));
            check("wrap_model", 32'(wrap), 32'(m_wrap));
        end
    endtask

    initial begin
        s_rst = 1'b1; s_run = 1'b0; s_mode = 2'b00; s_dir = 1'b0; s_speed = 2'b00;
        step_n(2);
        check("reset_led", 32'(led), 32'h1);
        check("reset_wrap", 32'(wrap), 32'h0);

        // Rotate toward MSB at speed 0.
        s_rst = 1'b0; s_run = 1'b1;
        step_n(8);
        check("rot_first_step", 32'(led), 32'h2);
        step_n(24);
        check("rot_back_to_1", 32'(led), 32'h1);
        check("rot_wrap", 32'(wrap), 32'h1);
        step_n(1);
        check("rot_wrap_single", 32'(wrap), 32'h0);

        // Bounce.
        s_mode = 2'b01;
        step_n(1);
        check("bnc_reload", 32'(led), 32'h1);
        check("bnc_reload_nowrap", 32'(wrap), 32'h0);
        step_n(8);
        check("bnc_step1", 32'(led), 32'h2);
        step_n(40);
        check("bnc_period", 32'(led), 32'h1);
        check("bnc_wrap", 32'(wrap), 32'h1);

        // Fill/drain.
        s_mode = 2'b10;
        step_n(1);
        check("fill_reload", 32'(led), 32'h0);
        step_n(32);
        check("fill_full", 32'(led), 32'hF);
        step_n(8);
        check("drain_first", 32'(led), 32'hE);
        step_n(24);
        check("fill_period", 32'(led), 32'h0);
        check("fill_wrap", 32'(wrap), 32'h1);

        // Blink.
        s_mode = 2'b11;
        step_n(1);
        check("blink_reload", 32'(led), 32'h0);
        step_n(8);
        check("blink_on", 32'(led), 32'hF);
        step_n(8);
        check("blink_off", 32'(led), 32'h0);
        check("blink_wrap", 32'(wrap), 32'h1);

        // Speed change with the counter part-way, then pause.
        s_mode = 2'b00;
        step_n(1);
        step_n(5);
        check("spd_before", 32'(led), 32'h1);
        s_speed = 2'd2;
        step_n(1);
        check("spd_immediate_tick", 32'(led), 32'h2);
        step_n(2);
        check("spd_period2", 32'(led), 32'h4);
        s_run = 1'b0;
        step_n(20);
        check("pause_hold", 32'(led), 32'h4);
        s_run = 1'b1;
        step_n(2);
        check("resume_step", 32'(led), 32'h8);

        // Reset mid-bounce while the bit is travelling down.
        s_speed = 2'd0; s_mode = 2'b01;
        step_n(1);
        step_n(24);
        check("bnc_at_top", 32'(led), 32'h8);
        s_rst = 1'b1;
        step_n(1);
        check("midrst_led", 32'(led), 32'h1);
        s_rst = 1'b0;
        step_n(1);
        check("post_rst_reload", 32'(led), 32'h1);
        check("post_rst_nowrap", 32'(wrap), 32'h0);
        step_n(8);
        check("post_rst_up1", 32'(led), 32'h2);
        step_n(8);
        check("post_rst_up2", 32'(led), 32'h4);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            s_rst = ($urandom_range(0, 299) == 0);
            s_run = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 119) == 0) s_mode  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 59) == 0)  s_speed = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0)  s_dir   = 1'($urandom_range(0, 1));
            step_n(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
